pattern_scan_controller: RTL

- Sequences a serial 4-bit pattern detector across a parallel data word.
- On `start`, it captures a word, a pattern and a mode, then shifts the word MSB-first into a detection window at one bit per cycle.
- It counts matches, records the first match position and pulses `done`.
- Used by software-visible status logic to scan captured bus words for a sync or marker sequence, e.g. 1011.

---
 rtl/pattern_scan_pkg.sv | 15 +
 rtl/pattern_match_window.sv | 55 +++++
 rtl/pattern_scan_controller.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pattern_scan_pkg.sv
// Shared types and default sizes for the pattern scan controller.
// Optional abort support is enabled by defining PATTERN_SCAN_ABORT_EN.
package pattern_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  localparam int DATA_W_DEF = 16;
  localparam int PAT_W_DEF  = 4;
  localparam int CNT_W_DEF  = 5;

endpackage

// File: rtl/pattern_match_window.sv
// Serial detection window: shift register, valid-count and comparator.
// match is combinational for the bit currently presented on bit_in.
module pattern_match_window
  import pattern_scan_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             match
);

  localparam int VW = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [VW-1:0] FULL = VW'(PAT_W - 1);

  logic [PAT_W-2:0] win_q, win_d;
  logic [VW-1:0]    vcnt_q, vcnt_d;
  logic [PAT_W-1:0] shifted;

  assign shifted = {win_q, bit_in};
  assign match   = bit_valid && (vcnt_q >= FULL)
                && (shifted == pattern);

  always_comb begin
    win_d  = win_q;
    vcnt_d = vcnt_q;
    if (clear) begin
      win_d  = '0;
      vcnt_d = '0;
    end else if (bit_valid) begin
      if (match && !overlap) begin
        vcnt_d = '0;
      end else begin
        win_d  = shifted[PAT_W-2:0];
        vcnt_d = (vcnt_q == FULL) ? FULL : vcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q  <= '0;
      vcnt_q <= '0;
    end else begin
      win_q  <= win_d;
      vcnt_q <= vcnt_d;
    end
  end

endmodule

// File: rtl/pattern_scan_controller.sv
// Scans a captured word MSB-first through the match window and reports results.
// Define PATTERN_SCAN_ABORT_EN to add the abort input and aborted flag.
module pattern_scan_controller
  import pattern_scan_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PAT_W  = PAT_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [PAT_W-1:0]  pattern,
  input  logic              overlap,
`ifdef PATTERN_SCAN_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CNT_W-1:0]  first_idx
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  scan_state_e       state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic              ovl_q, ovl_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  first_q, first_d;
  logic              found_q, found_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef PATTERN_SCAN_ABORT_EN
  logic              aborted_q, aborted_d;
`endif

  logic clear;
  logic bit_valid;
  logic match;

  assign clear     = (state_q == IDLE) && start;
  assign bit_valid = (state_q == SCAN);

  pattern_match_window #(
    .PAT_W(PAT_W)
  ) u_window (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .bit_valid(bit_valid),
    .bit_in   (word_q[DATA_W-1]),
    .pattern  (pat_q),
    .overlap  (ovl_q),
    .match    (match)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    pat_d   = pat_q;
    ovl_d   = ovl_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    found_d = found_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef PATTERN_SCAN_ABORT_EN
    aborted_d = aborted_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          word_d  = data_in;
          pat_d   = pattern;
          ovl_d   = overlap;
          idx_d   = '0;
          cnt_d   = '0;
          first_d = '0;
          found_d = 1'b0;
          busy_d  = 1'b1;
          state_d = SCAN;
`ifdef PATTERN_SCAN_ABORT_EN
          aborted_d = 1'b0;
`endif
        end
      end
      SCAN: begin
        busy_d = 1'b1;
        word_d = {word_q[DATA_W-2:0], 1'b0};
        idx_d  = idx_q + 1'b1;
        if (match) begin
          cnt_d   = cnt_q + 1'b1;
          found_d = 1'b1;
          if (!found_q) first_d = idx_q;
        end
        if (idx_q == LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
`ifdef PATTERN_SCAN_ABORT_EN
        if (abort) begin
          busy_d    = 1'b0;
          done_d    = 1'b1;
          aborted_d = 1'b1;
          state_d   = DONE;
        end
`endif
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      pat_q   <= '0;
      ovl_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      first_q <= '0;
      found_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PATTERN_SCAN_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      found_q <= found_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PATTERN_SCAN_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign found     = found_q;
  assign match_cnt = cnt_q;
  assign first_idx = first_q;
`ifdef PATTERN_SCAN_ABORT_EN
  assign aborted   = aborted_q;
`endif

endmodule
